// File: rtl/instr_stream_loader.sv
// instr_stream_loader
// Accepts RV32 instruction field bundles over a valid/ready handshake,
// encodes them as R/I/L/S/B-format words and writes them sequentially
// into instruction memory, one word per WRITE cycle.
//
// Optional feature macro: LOADER_NOP_PAD_EN
//   When defined, finish pads the remaining memory with NOPs
//   (addi x0,x0,0) before the loader reports done.
//
// All outputs come straight from flops; the next-state logic below
// computes every registered value, including inReady, from the next state.
module instr_stream_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              inValid,
    output logic              inReady,
    input  logic [2:0]        fmt,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [12:0]       imm,
    input  logic              finish,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [31:0]       memWdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err
);

`ifdef LOADER_NOP_PAD_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_PAD   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd3
    } state_t;
`endif

    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ZERO_C   = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0] ONE_C    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [31:0]     NOP_WORD = 32'h0000_0013;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;

    // Only format codes 0..4 map to an encoding.
    function automatic logic fmt_legal(input logic [2:0] f);
        logic ok;
        case (f)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4: ok = 1'b1;
            default:                      ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Packs the field bundle into an RV32 word; B drops imm[0].
    function automatic logic [31:0] encode_word(
        input logic [2:0]  f,
        input logic [4:0]  f_rd,
        input logic [4:0]  f_rs1,
        input logic [4:0]  f_rs2,
        input logic [2:0]  f_f3,
        input logic [6:0]  f_f7,
        input logic [12:0] f_imm
    );
        logic [31:0] w;
        case (f)
            3'd0:    w = {f_f7, f_rs2, f_rs1, f_f3, f_rd, OP_R};
            3'd1:    w = {f_imm[11:0], f_rs1, f_f3, f_rd, OP_I};
            3'd2:    w = {f_imm[11:0], f_rs1, f_f3, f_rd, OP_L};
            3'd3:    w = {f_imm[11:5], f_rs2, f_rs1, f_f3, f_imm[4:0], OP_S};
            3'd4:    w = {f_imm[12], f_imm[10:5], f_rs2, f_rs1, f_f3,
                          f_imm[4:1], f_imm[11], OP_B};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    state_t            state_r, state_s;
    logic [ADDR_W:0]   count_r, count_s;
    logic [31:0]       word_r, word_s;
    logic              we_r, we_s;
    logic              err_r, err_s;
    logic              done_r, done_s;
    logic              full_r, full_s;
    logic              ready_r, ready_s;

    // Next-state logic: clear wins, then handshake, then finish.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        word_s  = word_r;
        we_s    = 1'b0;
        err_s   = err_r;
        if (clear) begin
            state_s = ST_IDLE;
            count_s = ZERO_C;
            err_s   = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (inValid && ready_r) begin
                        if (fmt_legal(fmt)) begin
                            word_s  = encode_word(fmt, rd, rs1, rs2, funct3, funct7, imm);
                            we_s    = 1'b1;
                            state_s = ST_WRITE;
                        end else begin
                            // Bundle is consumed but dropped.
                            err_s   = 1'b1;
                            state_s = ST_IDLE;
                        end
                    end else if (finish) begin
`ifdef LOADER_NOP_PAD_EN
                        if (count_r != DEPTH_C) begin
                            word_s  = NOP_WORD;
                            we_s    = 1'b1;
                            state_s = ST_PAD;
                        end else begin
                            state_s = ST_DONE;
                        end
`else
                        state_s = ST_DONE;
`endif
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    count_s = count_r + ONE_C;
                    state_s = ST_IDLE;
                end
`ifdef LOADER_NOP_PAD_EN
                ST_PAD: begin
                    count_s = count_r + ONE_C;
                    if (count_s == DEPTH_C) begin
                        state_s = ST_DONE;
                    end else begin
                        we_s    = 1'b1;
                        state_s = ST_PAD;
                    end
                end
`endif
                ST_DONE: begin
                    state_s = ST_DONE;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
        ready_s = (state_s == ST_IDLE) && (count_s != DEPTH_C);
        full_s  = (count_s == DEPTH_C);
        done_s  = (state_s == ST_DONE);
    end

    // State and output registers; reset drops the write strobe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            count_r <= ZERO_C;
            word_r  <= 32'h0000_0000;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            done_r  <= 1'b0;
            full_r  <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            word_r  <= word_s;
            we_r    <= we_s;
            err_r   <= err_s;
            done_r  <= done_s;
            full_r  <= full_s;
            ready_r <= ready_s;
        end
    end

    assign inReady  = ready_r;
    assign memWe    = we_r;
    assign memAddr  = count_r[ADDR_W-1:0];
    assign memWdata = word_r;
    assign count    = count_r;
    assign full     = full_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_instr_stream_loader.sv
// tb_instr_stream_loader
// Scenario tasks driving instr_stream_loader; expected words come from a
// shift-and-mask encoder model and an expected write address counter.
module tb_instr_stream_loader;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst_n;
    logic              clear;
    logic              inValid;
    logic              inReady;
    logic [2:0]        fmt;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [12:0]       imm;
    logic              finish;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              done;
    logic              err;

    int vectors     = 0;
    int miscompares = 0;
    int m_count     = 0;

    instr_stream_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .inValid(inValid),
        .inReady(inReady), .fmt(fmt), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm), .finish(finish),
        .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .count(count), .full(full), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference encoder built from field positions with shifts and masks.
    function automatic logic [31:0] ref_word(input logic [2:0] f, input logic [4:0] v_rd,
                                             input logic [4:0] v_rs1, input logic [4:0] v_rs2,
                                             input logic [2:0] v_f3, input logic [6:0] v_f7,
                                             input logic [12:0] v_imm);
        int unsigned r, s1, s2, f3, f7, im, base, w;
        r = v_rd; s1 = v_rs1; s2 = v_rs2; f3 = v_f3; f7 = v_f7; im = v_imm;
        base = (s1 << 15) | (f3 << 12);
        case (f)
            3'd0: w = 32'h33 | (r << 7) | base | (s2 << 20) | (f7 << 25);
            3'd1: w = 32'h13 | (r << 7) | base | ((im & 32'hfff) << 20);
            3'd2: w = 32'h03 | (r << 7) | base | ((im & 32'hfff) << 20);
            3'd3: w = 32'h23 | ((im & 32'h1f) << 7) | base | (s2 << 20)
                      | (((im >> 5) & 32'h7f) << 25);
            3'd4: w = 32'h63 | (((im >> 11) & 32'h1) << 7) | (((im >> 1) & 32'hf) << 8)
                      | base | (s2 << 20) | (((im >> 5) & 32'h3f) << 25)
                      | (((im >> 12) & 32'h1) << 31);
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // Offers one bundle, waits (bounded) for the handshake and returns the
    // write-port view during the cycle after the accepting edge.
    task automatic send(input logic [2:0] f, input logic [4:0] v_rd, input logic [4:0] v_rs1,
                        input logic [4:0] v_rs2, input logic [2:0] v_f3, input logic [6:0] v_f7,
                        input logic [12:0] v_imm, input logic v_fin,
                        output logic hs, output logic [38:0] obs);
        @(negedge clk);
        fmt = f; rd = v_rd; rs1 = v_rs1; rs2 = v_rs2; funct3 = v_f3; funct7 = v_f7;
        imm = v_imm; finish = v_fin; inValid = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (inReady === 1'b1) begin
                hs = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (hs) @(negedge clk);
        inValid = 1'b0;
        finish  = 1'b0;
        obs = {memWe, memAddr, memWdata};
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        m_count = 0;
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({memWe, memAddr, memWdata, count, full, done, err, inReady} !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got we=%0b addr=%0d data=%h count=%0d full=%0b done=%0b err=%0b rdy=%0b, want all 0",
                     memWe, memAddr, memWdata, count, full, done, err, inReady);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({inReady, count} !== {1'b1, 7'd0}) begin
            miscompares++;
            $display("FAIL reset_release: got rdy=%0b count=%0d, want rdy=1 count=0", inReady, count);
        end
    endtask

    task automatic test_plan_vectors();
        logic [2:0]  t_f  [5] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd4};
        logic [4:0]  t_rd [5] = '{5'd1, 5'd3, 5'd5, 5'd0, 5'd0};
        logic [4:0]  t_s1 [5] = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd0};
        logic [4:0]  t_s2 [5] = '{5'd0, 5'd2, 5'd0, 5'd2, 5'd0};
        logic [2:0]  t_f3 [5] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd0};
        logic [12:0] t_im [5] = '{13'd5, 13'd0, 13'd4, 13'd8, 13'd8};
        logic [31:0] t_ex [5] = '{32'h00500093, 32'h002081B3, 32'h0040A283,
                                  32'h0020A423, 32'h00000463};
        logic hs;
        logic [38:0] obs;
        for (int i = 0; i < 5; i++) begin
            send(t_f[i], t_rd[i], t_s1[i], t_s2[i], t_f3[i], 7'd0, t_im[i], 1'b0, hs, obs);
            vectors++;
            if ({hs, obs} !== {1'b1, 1'b1, 6'(i), t_ex[i]}) begin
                miscompares++;
                $display("FAIL plan_word%0d: got hs=%0b we=%0b addr=%0d data=%h, want hs=1 we=1 addr=%0d data=%h",
                         i, hs, obs[38], obs[37:32], obs[31:0], i, t_ex[i]);
            end
            @(negedge clk);
            vectors++;
            if (count !== 7'(i + 1)) begin
                miscompares++;
                $display("FAIL plan_count%0d: got %0d, want %0d", i, count, i + 1);
            end
        end
        m_count = 5;
    endtask

    task automatic test_illegal_fmt();
        logic hs;
        logic [38:0] obs;
        send(3'd6, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom),
             13'($urandom), 1'b0, hs, obs);
        vectors++;
        if ({hs, obs[38]} !== 2'b10) begin
            miscompares++;
            $display("FAIL illegal_nowrite: got hs=%0b we=%0b, want hs=1 we=0", hs, obs[38]);
        end
        @(negedge clk);
        vectors++;
        if ({err, count} !== {1'b1, 7'(m_count)}) begin
            miscompares++;
            $display("FAIL illegal_err: got err=%0b count=%0d, want err=1 count=%0d", err, count, m_count);
        end
        send(3'd1, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 13'd1, 1'b0, hs, obs);
        vectors++;
        if ({hs, obs, err} !== {1'b1, 1'b1, 6'(m_count), ref_word(3'd1, 5'd2, 5'd2, 5'd0, 3'd0, 7'd0, 13'd1), 1'b1}) begin
            miscompares++;
            $display("FAIL illegal_sticky: got hs=%0b we=%0b addr=%0d data=%h err=%0b, want write at %0d and err=1",
                     hs, obs[38], obs[37:32], obs[31:0], err, m_count);
        end
        pulse_clear();
        vectors++;
        if ({err, count, done, memWe} !== 10'd0) begin
            miscompares++;
            $display("FAIL clear_state: got err=%0b count=%0d done=%0b we=%0b, want all 0", err, count, done, memWe);
        end
    endtask

    task automatic test_random_stream(input int n);
        logic hs;
        logic [38:0] obs;
        logic [2:0] f;
        logic [4:0] a, b, c;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [12:0] im;
        logic [31:0] exp_w;
        for (int i = 0; i < n; i++) begin
            f = 3'($urandom_range(0, 4)); a = 5'($urandom); b = 5'($urandom); c = 5'($urandom);
            f3 = 3'($urandom); f7 = 7'($urandom); im = 13'($urandom);
            exp_w = ref_word(f, a, b, c, f3, f7, im);
            send(f, a, b, c, f3, f7, im, 1'b0, hs, obs);
            vectors++;
            if ({hs, obs} !== {1'b1, 1'b1, 6'(m_count), exp_w}) begin
                miscompares++;
                $display("FAIL rand_word fmt=%0d: got hs=%0b we=%0b addr=%0d data=%h, want addr=%0d data=%h",
                         f, hs, obs[38], obs[37:32], obs[31:0], m_count, exp_w);
            end
            m_count++;
        end
        @(negedge clk);
        vectors++;
        if (count !== 7'(m_count)) begin
            miscompares++;
            $display("FAIL rand_count: got %0d, want %0d", count, m_count);
        end
    endtask

    task automatic test_finish_priority();
        logic hs;
        logic [38:0] obs;
        pulse_clear();
        send(3'd0, 5'd7, 5'd8, 5'd9, 3'd1, 7'h20, 13'd0, 1'b1, hs, obs);
        vectors++;
        if ({hs, obs} !== {1'b1, 1'b1, 6'd0, ref_word(3'd0, 5'd7, 5'd8, 5'd9, 3'd1, 7'h20, 13'd0)}) begin
            miscompares++;
            $display("FAIL finish_prio_write: got hs=%0b we=%0b addr=%0d data=%h", hs, obs[38], obs[37:32], obs[31:0]);
        end
        @(negedge clk);
        vectors++;
        if ({done, count} !== {1'b0, 7'd1}) begin
            miscompares++;
            $display("FAIL finish_prio_done: got done=%0b count=%0d, want done=0 count=1", done, count);
        end
`ifndef LOADER_NOP_PAD_EN
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        inValid = 1'b1;
        vectors++;
        if ({done, memWe, inReady, count} !== {1'b1, 1'b0, 1'b0, 7'd1}) begin
            miscompares++;
            $display("FAIL finish_direct: got done=%0b we=%0b rdy=%0b count=%0d, want done=1 we=0 rdy=0 count=1",
                     done, memWe, inReady, count);
        end
        @(negedge clk);
        @(negedge clk);
        inValid = 1'b0;
        vectors++;
        if ({done, memWe, count} !== {1'b1, 1'b0, 7'd1}) begin
            miscompares++;
            $display("FAIL done_hold: got done=%0b we=%0b count=%0d, want done=1 we=0 count=1", done, memWe, count);
        end
`endif
        pulse_clear();
    endtask

    task automatic test_full();
        int writes_seen = 0;
        test_random_stream(DEPTH);
        vectors++;
        if ({full, inReady, count} !== {1'b1, 1'b0, 7'd64}) begin
            miscompares++;
            $display("FAIL full_flag: got full=%0b rdy=%0b count=%0d, want full=1 rdy=0 count=64", full, inReady, count);
        end
        fmt = 3'd1; inValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (memWe === 1'b1) writes_seen++;
        end
        inValid = 1'b0;
        vectors++;
        if ({writes_seen[7:0], count} !== {8'd0, 7'd64}) begin
            miscompares++;
            $display("FAIL full_ignore: got %0d writes count=%0d, want 0 writes count=64", writes_seen, count);
        end
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        vectors++;
        if ({done, memWe} !== 2'b10) begin
            miscompares++;
            $display("FAIL full_finish: got done=%0b we=%0b, want done=1 we=0", done, memWe);
        end
        pulse_clear();
        vectors++;
        if ({done, full, count, inReady} !== {1'b0, 1'b0, 7'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL done_clear: got done=%0b full=%0b count=%0d rdy=%0b, want 0 0 0 1", done, full, count, inReady);
        end
    endtask

`ifdef LOADER_NOP_PAD_EN
    task automatic test_pad();
        int bad = 0;
        test_random_stream(3);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        for (int a = 3; a < DEPTH; a++) begin
            if ({memWe, memAddr, memWdata} !== {1'b1, 6'(a), 32'h00000013}) begin
                bad++;
                if (bad == 1)
                    $display("FAIL pad_word: at addr %0d got we=%0b addr=%0d data=%h, want NOP", a, memWe, memAddr, memWdata);
            end
            @(negedge clk);
        end
        vectors++;
        if (bad != 0) miscompares++;
        vectors++;
        if ({done, memWe, count} !== {1'b1, 1'b0, 7'd64}) begin
            miscompares++;
            $display("FAIL pad_done: got done=%0b we=%0b count=%0d, want 1 0 64", done, memWe, count);
        end
        pulse_clear();
    endtask
`endif

    task automatic test_reset_mid_write();
        logic hs;
        logic [38:0] obs;
        send(3'd2, 5'd4, 5'd6, 5'd0, 3'd2, 7'd0, 13'h7ff, 1'b0, hs, obs);
        vectors++;
        if ({hs, obs[38]} !== 2'b11) begin
            miscompares++;
            $display("FAIL midwrite_setup: got hs=%0b we=%0b, want 1 1", hs, obs[38]);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({memWe, memAddr, memWdata, count, full, done, err, inReady} !== 48'h0) begin
            miscompares++;
            $display("FAIL midwrite_reset: got we=%0b addr=%0d data=%h count=%0d rdy=%0b, want all 0",
                     memWe, memAddr, memWdata, count, inReady);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({inReady, count, memWe} !== {1'b1, 7'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL midwrite_recover: got rdy=%0b count=%0d we=%0b", inReady, count, memWe);
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; inValid = 1'b0; finish = 1'b0;
        fmt = 3'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7 = 7'd0; imm = 13'd0;
        test_reset();
        test_plan_vectors();
        test_illegal_fmt();
        test_random_stream(24);
        test_finish_priority();
        test_full();
`ifdef LOADER_NOP_PAD_EN
        test_pad();
`endif
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/instr_stream_loader.md
Name: instr_stream_loader

Overview:
Writer-side counterpart of the control decoder. Accepts instruction fields over a valid/ready handshake and encodes R/I/L/S/B-format RV32 words with the same opcode classes the decoder consumes. Writes the words sequentially into instruction memory. Used to preload programs and to drive decoder and datapath benches with structurally correct instructions.

Parameters:
DEPTH, 64, number of instruction-memory words that can be written (addresses 0..DEPTH-1).
ADDR_W, 6, width of memAddr/count; must satisfy 2**ADDR_W >= DEPTH.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
clear  input  1  synchronous restart: address to 0, err/done cleared, FSM to IDLE.
inValid  input  1  field bundle valid.
inReady  output  1  loader can accept a bundle this cycle.
fmt  input  3  0=R, 1=I, 2=L, 3=S, 4=B, 5..7 illegal.
rd  input  5  destination register.
rs1  input  5  source register 1.
rs2  input  5  source register 2.
funct3  input  3  funct3 field.
funct7  input  7  funct7 field (R only).
imm  input  13  immediate; I/L/S use imm[11:0]; B uses imm[12:1], imm[0] ignored.
finish  input  1  end of program, sampled only in IDLE.
memWe  output  1  instruction-memory write strobe.
memAddr  output  ADDR_W  write address.
memWdata  output  32  encoded instruction.
count  output  ADDR_W+1  words written so far.
full  output  1  count == DEPTH.
done  output  1  program complete (sticky until clear/reset).
err  output  1  sticky: an illegal fmt was received.

Behaviour:
- Reset (rst_n low, asynchronous): FSM=IDLE; memWe=0, memAddr=0, memWdata=0, count=0, full=0, done=0, err=0, inReady=0 during reset.
- States: IDLE, WRITE, PAD (optional feature only), DONE.
- IDLE: inReady = !full. Handshake when inValid & inReady. The fields are encoded and registered, and the FSM goes to WRITE.
- WRITE (exactly 1 cycle): memWe=1, memAddr=count[ADDR_W-1:0], memWdata=registered word, inReady=0. At the next edge, count increments and the FSM returns to IDLE. Maximum throughput is one word every 2 cycles. Latency is accept edge to memWe high in the following cycle.
- Encoding (opcode in [6:0]):
  - R: {funct7, rs2, rs1, funct3, rd, 7'b0110011}
  - I: {imm[11:0], rs1, funct3, rd, 7'b0010011}
  - L: {imm[11:0], rs1, funct3, rd, 7'b0000011}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}
- Illegal fmt: the handshake still completes and the bundle is dropped (no WRITE, count unchanged). err is set and stays set until clear or reset. The FSM stays in IDLE.
- full: count==DEPTH. inReady=0 and inValid is ignored. finish is still accepted.
- finish in IDLE with no handshake in the same cycle goes to DONE. If inValid&inReady and finish are both high in the same cycle, the bundle takes priority and finish is ignored that cycle.
- DONE: done=1, inReady=0, memWe=0. Leaves only on clear or reset.
- clear: takes priority over all other inputs in every state. Next cycle: IDLE, count=0, done=0, err=0, memWe=0.
- Reset mid-WRITE: the write is abandoned and memWe drops immediately.

Optional Feature:
LOADER_NOP_PAD_EN.
- Defined: finish in IDLE with count<DEPTH enters PAD. PAD writes 32'h00000013 (addi x0,x0,0) with memWe=1 each cycle, one address per cycle, until count==DEPTH, then goes to DONE. finish while already full goes straight to DONE. clear aborts PAD.
- Undefined: the PAD state does not exist and finish goes directly to DONE.

Test Plan:
- Reset, then fmt=I, rd=1, rs1=0, funct3=0, imm=5 -> memWe=1 at addr 0 with 0x00500093; count=1.
- R rd=3, rs1=1, rs2=2, f3=0, f7=0 -> 0x002081B3; then L rd=5, rs1=1, f3=2, imm=4 -> 0x0040A283 at addr 2 (after addi).
- S rs1=1, rs2=2, f3=2, imm=8 -> 0x0020A423; B rs1=0, rs2=0, f3=0, imm=8 -> 0x00000463.
- fmt=6 with inValid -> no memWe, count unchanged, err=1; clear -> err=0, count=0.
- Stream DEPTH valid bundles with inValid held high -> full=1, inReady=0, and a further bundle produces no write; finish -> done=1 (with LOADER_NOP_PAD_EN, after 3 words and finish: addresses 3..63 receive 0x00000013, then done=1).
- Assert rst_n low during a WRITE cycle -> memWe=0 immediately; all outputs at reset values.
